// File: rtl/multdiv_pkg.sv
// Shared types and sizing helpers for the iterative signed multiply/divide unit.
package multdiv_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;
  typedef enum logic {OP_MULT, OP_DIV} op_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH + 1);

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  // Everything about the accepted operation that the sign-fix stage needs.
  typedef struct packed {
    op_t  op;
    logic res_neg;
    logic rem_neg;
    logic b_zero;
    logic div_ovf;
  } req_t;

endpackage

// File: rtl/multdiv_iter_core.sv
// Shared radix-2 datapath: shift-add multiply or restoring divide on unsigned magnitudes.
module multdiv_iter_core
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load,
  input  logic               en,
  input  op_t                op,
  input  logic [WIDTH-1:0]   a_mag,
  input  logic [WIDTH-1:0]   b_mag,
  output logic [2*WIDTH-1:0] acc
);

  logic [WIDTH-1:0] m_q;
  op_t              op_q;
  logic             is_div;
  logic [WIDTH:0]   x;
  logic [WIDTH+1:0] y;
  logic [WIDTH+1:0] s;
  logic             neg;
  logic [WIDTH:0]   hi_n;

  // One W+2 bit adder serves both ops: add for multiply, trial subtract for divide.
  always_comb begin
    is_div = (op_q == OP_DIV);
    x      = is_div ? {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} : {1'b0, acc[2*WIDTH-1:WIDTH]};
    y      = is_div ? ~{2'b00, m_q} : {2'b00, m_q};
    s      = {1'b0, x} + y + {{(WIDTH+1){1'b0}}, is_div};
    neg    = s[WIDTH+1];
    hi_n   = acc[0] ? s[WIDTH:0] : {1'b0, acc[2*WIDTH-1:WIDTH]};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc  <= '0;
      m_q  <= '0;
      op_q <= OP_MULT;
    end else if (load) begin
      op_q <= op;
      m_q  <= (op == OP_DIV) ? b_mag : a_mag;
      acc  <= {{WIDTH{1'b0}}, ((op == OP_DIV) ? a_mag : b_mag)};
    end else if (en) begin
      if (is_div)
        acc <= {(neg ? x[WIDTH-1:0] : s[WIDTH-1:0]), acc[WIDTH-2:0], ~neg};
      else
        acc <= {hi_n, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide: FSM, operand capture, sign fix, exceptions, result hold.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_inputRDY,
  output logic             data_resultRDY
);

  localparam int CW = cnt_width(WIDTH);

  state_t             state, state_n;
  logic [CW-1:0]      cnt;
  req_t               req;
  logic               start_ok, start_bad, last_step;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] acc, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;
  logic [WIDTH-1:0]   fix_res, fix_rem;
  logic               fix_exc, mul_ovf;

  assign data_inputRDY = reset_n && ((state == IDLE) || (state == DONE));
  assign start_ok      = data_inputRDY && (ctrl_MULT ^ ctrl_DIV);
  assign start_bad     = data_inputRDY && ctrl_MULT && ctrl_DIV;
  assign last_step     = (cnt == CW'(WIDTH - 1));
  assign a_mag         = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign b_mag         = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: begin
        if (start_bad)     state_n = DONE;
        else if (start_ok) state_n = BUSY;
      end
      BUSY:    if (last_step) state_n = FIX;
      FIX:     state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      req <= '0;
    end else if (start_ok) begin
      cnt         <= '0;
      req.op      <= ctrl_DIV ? OP_DIV : OP_MULT;
      req.res_neg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      req.rem_neg <= data_operandA[WIDTH-1];
      req.b_zero  <= (data_operandB == '0);
      req.div_ovf <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&data_operandB);
    end else if (state == BUSY) begin
      cnt <= cnt + CW'(1);
    end
  end

  multdiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (start_ok),
    .en      (state == BUSY),
    .op      (ctrl_DIV ? OP_DIV : OP_MULT),
    .a_mag   (a_mag),
    .b_mag   (b_mag),
    .acc     (acc)
  );

  // Product fits in WIDTH signed bits only if its top WIDTH+1 bits are all equal.
  always_comb begin
    prod_s  = req.res_neg ? -acc : acc;
    mul_ovf = !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));
    quo_s   = req.res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_s   = req.rem_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    fix_res = prod_s[WIDTH-1:0];
    fix_rem = '0;
    fix_exc = mul_ovf;
    if (req.op == OP_DIV) begin
      if (req.b_zero) begin
        fix_res = '0;
        fix_exc = 1'b1;
      end else begin
        fix_res = quo_s;
        fix_rem = rem_s;
        fix_exc = req.div_ovf;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else if (start_bad) begin
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b1;
      data_resultRDY <= 1'b1;
    end else if (start_ok) begin
      data_resultRDY <= 1'b0;
    end else if (state == FIX) begin
      data_result    <= fix_res;
      data_remainder <= fix_rem;
      data_exception <= fix_exc;
      data_resultRDY <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed and randomized checks of multdiv_unit against an arithmetic reference model.
module tb_multdiv_unit;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset_n = 1'b1;
  logic [W-1:0] data_operandA = '0, data_operandB = '0;
  logic         ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
  logic [W-1:0] data_result, data_remainder;
  logic         data_exception, data_inputRDY, data_resultRDY;

  int checks = 0;
  int failures = 0;

  multdiv_unit #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_inputRDY  (data_inputRDY),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain signed arithmetic on 64-bit integers.
  function automatic void model(input logic is_div, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic [W-1:0] rm, output logic e);
    longint p, lim;
    int sx, sy;
    sx  = int'(x);
    sy  = int'(y);
    lim = 64'sd2147483648;
    if (!is_div) begin
      p  = longint'(sx) * longint'(sy);
      r  = p[W-1:0];
      rm = '0;
      e  = (p >= lim) || (p < -lim);
    end else if (y == 0) begin
      r = '0; rm = '0; e = 1'b1;
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      r = x; rm = '0; e = 1'b1;
    end else begin
      r  = sx / sy;
      rm = sx % sy;
      e  = 1'b0;
    end
  endfunction

  task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic is_div);
    logic [W-1:0] er, erm;
    logic         ee;
    int           lat;
    model(is_div, x, y, er, erm, ee);
    @(negedge clock);
    data_operandA = x; data_operandB = y;
    ctrl_MULT = !is_div; ctrl_DIV = is_div;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    chk({tag, "_rdy_drop"}, data_resultRDY, 1'b0);
    chk({tag, "_inrdy_busy"}, data_inputRDY, 1'b0);
    lat = 0;
    while (!data_resultRDY && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, W + 1);
    chk({tag, "_result"}, data_result, er);
    chk({tag, "_rem"}, data_remainder, erm);
    chk({tag, "_exc"}, data_exception, ee);
  endtask

  initial begin
    logic [W-1:0] x, y;
    logic [W-1:0] corners [5];
    logic         is_div;
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    #1 reset_n = 1'b0;
    #20;
    chk("rst_result", data_result, 0);
    chk("rst_rem", data_remainder, 0);
    chk("rst_exc", data_exception, 0);
    chk("rst_rdy", data_resultRDY, 0);
    chk("rst_inrdy", data_inputRDY, 0);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;
    chk("post_rst_inrdy", data_inputRDY, 1);

    do_op("mul_7x-6", 32'd7, -32'sd6, 1'b0);
    do_op("mul_ovf", 32'h0001_0000, 32'h0001_0000, 1'b0);
    do_op("mul_m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op("div_m7_2", -32'sd7, 32'd2, 1'b0 | 1'b1);
    do_op("div_5_0", 32'd5, 32'd0, 1'b1);
    do_op("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

    repeat (3) @(posedge clock);
    #1;
    chk("hold_result", data_result, 32'h8000_0000);
    chk("hold_exc", data_exception, 1);
    chk("hold_rdy", data_resultRDY, 1);

    // Reset partway through a divide.
    @(negedge clock);
    data_operandA = 32'h1234_5678; data_operandB = 32'd7; ctrl_DIV = 1'b1;
    @(posedge clock); #1 ctrl_DIV = 1'b0;
    repeat (9) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_result", data_result, 0);
    chk("midrst_rem", data_remainder, 0);
    chk("midrst_exc", data_exception, 0);
    chk("midrst_rdy", data_resultRDY, 0);
    chk("midrst_inrdy", data_inputRDY, 0);
    @(negedge clock) reset_n = 1'b1;
    do_op("mul_3x4", 32'd3, 32'd4, 1'b0);

    // Illegal start, then a start from DONE.
    @(negedge clock);
    data_operandA = $urandom; data_operandB = $urandom;
    ctrl_MULT = 1'b1; ctrl_DIV = 1'b1;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    chk("ill_rdy", data_resultRDY, 1);
    chk("ill_exc", data_exception, 1);
    chk("ill_result", data_result, 0);
    chk("ill_rem", data_remainder, 0);
    chk("ill_inrdy", data_inputRDY, 1);
    do_op("after_ill", 32'd100, -32'sd9, 1'b1);

    // Back-to-back: each do_op starts in the first DONE cycle of the previous one.
    do_op("b2b_0", 32'd12345, 32'd678, 1'b0);
    do_op("b2b_1", -32'sd1000, 32'd33, 1'b1);

    for (int i = 0; i < 40; i++) begin
      is_div = 1'($urandom_range(0, 1));
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(0, 3))
          0:       x = $urandom;
          1:       x = 32'($urandom_range(0, 200)) - 32'd100;
          2:       x = 32'($signed($urandom) >>> $urandom_range(8, 30));
          default: x = corners[$urandom_range(0, 4)];
        endcase
        if (k == 0) y = x;
      end
      do_op($sformatf("rnd%0d", i), y, x, is_div);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
